// File: rtl/seg_scroll_ctrl.sv
// Scrolling message controller for a 6-digit 7-segment display: buffers patterns, then steps a window across them.
// Build option: define SEG_SCROLL_LOOP_EN to honour the loop input; otherwise every scroll ends with done.
module seg_scroll_ctrl #(
  parameter int DIV   = 25000000,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [6:0] wr_data,
  output logic       wr_ready,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = AW + 2;
  localparam int PW = 26;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] len, len_nxt;
  logic [LW-1:0] pos, pos_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          loop_lat, loop_lat_nxt;
  logic          done_nxt;
  logic          wr_en;
  logic          loop_eff;
  logic [CW-1:0] idx;
  logic [6:0]    win [6];
  logic [6:0]    mem [DEPTH];

`ifdef SEG_SCROLL_LOOP_EN
  assign loop_eff = loop;
`else
  assign loop_eff = loop & 1'b0;
`endif

  assign wr_ready = (state == IDLE) && (len < LW'(DEPTH));
  assign busy     = (state == SCROLL);

  always_comb begin
    state_nxt    = state;
    len_nxt      = len;
    pos_nxt      = pos;
    presc_nxt    = presc;
    loop_lat_nxt = loop_lat;
    done_nxt     = 1'b0;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        // clear beats a same-cycle write; start sees the post-write length
        if (clear) begin
          len_nxt = '0;
        end else if (wr_valid && wr_ready) begin
          wr_en   = 1'b1;
          len_nxt = len + 1'b1;
        end
        if (start && (len_nxt != '0)) begin
          state_nxt    = SCROLL;
          pos_nxt      = '0;
          presc_nxt    = '0;
          loop_lat_nxt = loop_eff;
        end
      end
      SCROLL: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (presc == PW'(DIV - 1)) begin
          presc_nxt = '0;
          if (pos == len) begin
            if (loop_lat) begin
              pos_nxt = '0;
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            pos_nxt = pos + 1'b1;
          end
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window index is one bit wider than len so pos+5 never aliases into the buffer
  always_comb begin
    idx = '0;
    for (int j = 0; j < 6; j++) begin
      win[5-j] = BLANK;
      idx = CW'(pos) + CW'(j);
      if ((state == SCROLL) && (idx < CW'(len))) begin
        win[5-j] = mem[idx[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[len[AW-1:0]] <= wr_data;
    end
  end

  // Stage p0 -> p1: control registers and registered digit outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      pos      <= '0;
      presc    <= '0;
      loop_lat <= 1'b0;
      done     <= 1'b0;
      seg0     <= BLANK;
      seg1     <= BLANK;
      seg2     <= BLANK;
      seg3     <= BLANK;
      seg4     <= BLANK;
      seg5     <= BLANK;
    end else begin
      state    <= state_nxt;
      len      <= len_nxt;
      pos      <= pos_nxt;
      presc    <= presc_nxt;
      loop_lat <= loop_lat_nxt;
      done     <= done_nxt;
      seg0     <= win[0];
      seg1     <= win[1];
      seg2     <= win[2];
      seg3     <= win[3];
      seg4     <= win[4];
      seg5     <= win[5];
    end
  end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Scoreboard bench for seg_scroll_ctrl (DIV=4, DEPTH=16) against a queue/array reference model.
module tb_seg_scroll_ctrl;

  localparam int DIV   = 4;
  localparam int DEPTH = 16;
`ifdef SEG_SCROLL_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_data = '0;
  logic       wr_ready;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;
  logic       busy, done;

  seg_scroll_ctrl #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear(clear), .start(start), .stop(stop), .loop(loop),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [41:0] seg;
    logic        busy;
    logic        done;
    logic        wr_ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: message as an array plus length, scroll as a cycle count
  bit         m_scroll = 1'b0;
  int         m_len = 0;
  int         m_pos = 0;
  int         m_cyc = 0;
  bit         m_loop = 1'b0;
  logic [6:0] m_buf [DEPTH];

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({seg5, seg4, seg3, seg2, seg1, seg0} !== mon_e.seg) begin
        failures++;
        $display("FAIL segs t=%0t got=%h want=%h", $time,
                 {seg5, seg4, seg3, seg2, seg1, seg0}, mon_e.seg);
      end
      checks++;
      if ({busy, done, wr_ready} !== {mon_e.busy, mon_e.done, mon_e.wr_ready}) begin
        failures++;
        $display("FAIL ctrl(busy,done,wr_ready) t=%0t got=%b%b%b want=%b%b%b", $time,
                 busy, done, wr_ready, mon_e.busy, mon_e.done, mon_e.wr_ready);
      end
    end
  end

  task automatic cyc(input logic rn, input logic wv, input logic [6:0] wd, input logic cl,
                     input logic st, input logic sp, input logic lp);
    exp_t       e;
    logic [6:0] s [6];
    @(negedge clk);
    #1;
    rst_n = rn; wr_valid = wv; wr_data = wd; clear = cl; start = st; stop = sp; loop = lp;
    for (int j = 0; j < 6; j++) s[5-j] = (m_scroll && (m_pos + j < m_len)) ? m_buf[m_pos + j] : 7'h7F;
    e.done = 1'b0;
    if (!rn) begin
      m_scroll = 1'b0; m_len = 0; m_pos = 0; m_cyc = 0;
      for (int j = 0; j < 6; j++) s[j] = 7'h7F;
    end else if (!m_scroll) begin
      if (cl) m_len = 0;
      else if (wv && m_len < DEPTH) begin m_buf[m_len] = wd; m_len++; end
      if (st && m_len > 0) begin
        m_scroll = 1'b1; m_pos = 0; m_cyc = 0; m_loop = LOOP_EN && lp;
      end
    end else if (sp) begin
      m_scroll = 1'b0;
    end else begin
      m_cyc++;
      if (m_cyc % DIV == 0) begin
        if (m_pos < m_len) m_pos++;
        else if (m_loop) m_pos = 0;
        else begin m_scroll = 1'b0; e.done = 1'b1; end
      end
    end
    e.seg = {s[5], s[4], s[3], s[2], s[1], s[0]};
    e.busy = m_scroll;
    e.wr_ready = !m_scroll && (m_len < DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 7'h00, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [6:0] d);
    cyc(1, 1, d, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 7'h00, 0, 0, 0, 0);
    cyc(0, 1, 7'h55, 0, 1, 0, 0);
    // Three-character message, single pass
    wr(7'h01); wr(7'h02); wr(7'h03);
    cyc(1, 0, 7'h00, 0, 1, 0, 0);
    idle(22);
    // Length retained: restart replays the same window
    cyc(1, 0, 7'h00, 0, 1, 0, 0);
    idle(8);
    cyc(1, 0, 7'h00, 0, 0, 1, 0);
    idle(2);
    // Clear beats a same-cycle write; start with empty buffer is ignored
    cyc(1, 1, 7'h11, 1, 0, 0, 0);
    cyc(1, 0, 7'h00, 0, 1, 0, 0);
    idle(2);
    // Fill to capacity plus one refused write
    for (int i = 0; i < DEPTH + 1; i++) wr(7'($urandom_range(0, 127)));
    cyc(1, 0, 7'h00, 0, 1, 0, 0);
    idle(12);
    cyc(1, 1, 7'h22, 1, 1, 1, 0);
    idle(2);
    // Looping two-character message, then stop
    cyc(1, 1, 7'h33, 1, 0, 0, 0);
    wr(7'($urandom_range(0, 127))); wr(7'($urandom_range(0, 127)));
    cyc(1, 0, 7'h00, 0, 1, 0, 1);
    idle(30);
    cyc(1, 0, 7'h00, 0, 0, 1, 0);
    idle(2);
    // Single character with loop requested
    cyc(1, 1, 7'h44, 1, 0, 0, 0);
    wr(7'h5A);
    cyc(1, 0, 7'h00, 0, 1, 0, 1);
    idle(12);
    // Reset in the middle of a scroll, with start and write also asserted
    cyc(1, 0, 7'h00, 0, 1, 0, 0);
    idle(5);
    cyc(0, 1, 7'h66, 0, 1, 1, 0);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1), 7'($urandom_range(0, 127)),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
